regfile_init_writer: RTL and testbench

REGFILE_INIT_WRITER -- requirements
Module: regfile_init_writer

---
 rtl/regfile_init_writer.sv | 95 +++++++++
 tb/tb_regfile_init_writer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_init_writer.sv
// Register-file initializer: sweeps every entry after reset or on start_init,
// then forwards pipeline write-backs with one cycle of registered latency.
module regfile_init_writer #(
  parameter int NUM_REGS  = 32,
  parameter int INIT_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_init,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  output logic        RegWrite,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        init_busy,
  output logic        init_done
);

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t     state, state_nxt;
  logic [4:0] idx, idx_nxt;
  wr_t        wr_q, wr_d;
  logic       busy_d, done_d;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_d      = wr_q;
    wr_d.we   = 1'b0;
    busy_d    = init_busy;
    done_d    = init_done;
    wb_stall  = (state != RUN) | start_init;
    case (state)
      INIT: begin
        // start_init is deliberately not looked at here: a sweep runs to completion
        wr_d.we   = 1'b1;
        wr_d.addr = idx;
        wr_d.data = (INIT_MODE == 1) ? {27'd0, idx} : 32'd0;
        if (idx == LAST_IDX) begin
          state_nxt = RUN;
          idx_nxt   = 5'd0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          idx_nxt = idx + 5'd1;
        end
      end
      RUN: begin
        if (start_init) begin
          state_nxt = INIT;
          idx_nxt   = 5'd0;
          busy_d    = 1'b1;
        end else if (wb_valid) begin
          // $zero keeps its address/data update but is never written
          wr_d.we   = (wb_reg != 5'd0);
          wr_d.addr = wb_reg;
          wr_d.data = wb_data;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      idx       <= 5'd0;
      wr_q      <= '0;
      init_busy <= 1'b1;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      wr_q      <= wr_d;
      init_busy <= busy_d;
      init_done <= done_d;
    end
  end

  assign RegWrite   = wr_q.we;
  assign write_reg  = wr_q.addr;
  assign write_data = wr_q.data;

endmodule

// File: tb/tb_regfile_init_writer.sv
// Scoreboard bench for regfile_init_writer (INIT_MODE=1): stimulus pushes
// expected writes, a negedge monitor pops and compares every RegWrite.
module tb_regfile_init_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_init;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        init_busy;
  logic        init_done;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  regfile_init_writer #(.NUM_REGS(32), .INIT_MODE(1)) dut (
    .clk(clk), .rst(rst), .start_init(start_init), .wb_valid(wb_valid),
    .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
    .init_busy(init_busy), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep();
    for (int k = 0; k < 32; k++) push(5'(k), 32'(k));
  endtask

  // Monitor: every observed write must match the head of the scoreboard
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got reg %0d data %0h expected no write at %0t",
                 write_reg, write_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_reg", 32'(write_reg), 32'(e.r));
        check("wr_data", write_data, e.d);
      end
    end
  end

  // 32 INIT cycles after the edge that entered INIT; optional start_init glitch
  task automatic sweep(input logic done_before, input int glitch_at);
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk);
      #1 start_init = (c == glitch_at);
      @(negedge clk);
      check("sweep_busy", 32'(init_busy), 32'(c < 32));
      check("sweep_stall", 32'(wb_stall), 32'(c < 32 || start_init));
      check("sweep_done", 32'(init_done), 32'(done_before || c == 32));
    end
    start_init = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start_init = 1'b0; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_reg", 32'(write_reg), 32'd0);
    check("rst_data", write_data, 32'd0);
    check("rst_busy", 32'(init_busy), 32'd1);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_stall", 32'(wb_stall), 32'd1);

    // Reset release with a write-back held throughout INIT
    @(posedge clk);
    #1 rst = 1'b1;
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'h55;
    push_sweep();
    push(5'd5, 32'h55);
    sweep(1'b0, 0);
    @(posedge clk);
    #1 wb_valid = 1'b0;
    @(negedge clk);
    check("run_stall", 32'(wb_stall), 32'd0);

    // Single request, then idle hold
    @(posedge clk);
    #1 wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'hDEADBEEF;
    push(5'd7, 32'hDEADBEEF);
    @(posedge clk);
    #1 wb_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_regwrite", 32'(RegWrite), 32'd0);
    check("idle_hold_reg", 32'(write_reg), 32'd7);
    check("idle_hold_data", write_data, 32'hDEADBEEF);

    // $zero write-back is suppressed but address/data update
    @(posedge clk);
    #1 wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'h1234;
    @(posedge clk);
    #1 wb_valid = 1'b0;
    @(negedge clk);
    check("zero_regwrite", 32'(RegWrite), 32'd0);
    check("zero_reg", 32'(write_reg), 32'd0);
    check("zero_data", write_data, 32'h1234);

    // Back-to-back requests, no bubble
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1 wb_valid = 1'b1; wb_reg = 5'(i + 20); wb_data = 32'hA000 + 32'(i);
      push(5'(i + 20), 32'hA000 + 32'(i));
      if (i > 1) begin
        @(negedge clk);
        check("b2b_regwrite", 32'(RegWrite), 32'd1);
      end
    end
    @(posedge clk);
    #1 wb_valid = 1'b0;
    @(negedge clk);
    check("b2b_last_regwrite", 32'(RegWrite), 32'd1);

    // start_init collides with a request; request is held across the sweep
    @(posedge clk);
    #1 start_init = 1'b1; wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h99;
    #1 check("start_stall", 32'(wb_stall), 32'd1);
    push_sweep();
    push(5'd9, 32'h99);
    @(posedge clk);
    #1 start_init = 1'b0;
    @(negedge clk);
    check("start_no_write", 32'(RegWrite), 32'd0);
    check("start_busy", 32'(init_busy), 32'd1);
    check("start_done_kept", 32'(init_done), 32'd1);
    sweep(1'b1, 5);
    @(posedge clk);
    #1 wb_valid = 1'b0;

    // Reset in the middle of a sweep
    @(posedge clk);
    #1 start_init = 1'b1;
    @(posedge clk);
    #1 start_init = 1'b0;
    for (int k = 0; k < 10; k++) push(5'(k), 32'(k));
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_regwrite", 32'(RegWrite), 32'd0);
    check("mid_rst_reg", 32'(write_reg), 32'd0);
    check("mid_rst_data", write_data, 32'd0);
    check("mid_rst_busy", 32'(init_busy), 32'd1);
    check("mid_rst_done", 32'(init_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    push_sweep();
    sweep(1'b0, 0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
